// File: rtl/wbq_pkg.sv
// Shared defaults and entry layout for the writeback queue.
// Optional forwarding datapath is enabled by defining WBQ_FORWARD_EN.
package wbq_pkg;

  localparam int WBQ_ADDR_W = 5;
  localparam int WBQ_DATA_W = 32;

  typedef struct packed {
    logic [WBQ_ADDR_W-1:0] da;
    logic [WBQ_DATA_W-1:0] d;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Occupancy-masked address compare over the queue slots, oldest to youngest.
// Returns youngest matching data only when WBQ_FORWARD_EN is defined.
module wbq_match
  import wbq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WBQ_ADDR_W,
  parameter int DATA_W = WBQ_DATA_W
) (
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  da_i,
`ifdef WBQ_FORWARD_EN
  input  logic [DEPTH-1:0][DATA_W-1:0]  d_i,
`endif
  input  logic [$clog2(DEPTH)-1:0]      head_i,
  input  logic [$clog2(DEPTH):0]        count_i,
  output logic                          hit_o,
  output logic [DATA_W-1:0]             data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  // Walk slots in age order so the last hit seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if ((CW'(k) < count_i) && (addr_i != '0) && (da_i[idx] == addr_i)) begin
        hit_o = 1'b1;
`ifdef WBQ_FORWARD_EN
        data_o = d_i[idx];
`endif
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Pending register-write FIFO fed by a load and an ALU producer, draining one entry per cycle.
// Define WBQ_FORWARD_EN to enable youngest-entry forwarding on fwd_a/fwd_b.
module writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WBQ_DATA_W,
  parameter int ADDR_W = WBQ_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_da,
  input  logic [DATA_W-1:0]        mem_d,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_da,
  input  logic [DATA_W-1:0]        alu_d,
  output logic                     rf_rw,
  output logic [ADDR_W-1:0]        rf_da,
  output logic [DATA_W-1:0]        rf_d,
  input  logic [ADDR_W-1:0]        aa,
  input  logic [ADDR_W-1:0]        ba,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic                     fwd_a_hit,
  output logic [DATA_W-1:0]        fwd_a,
  output logic                     fwd_b_hit,
  output logic [DATA_W-1:0]        fwd_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  // Same layout as wbq_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CW-1:0]    count_q, count_d, free;
  logic             mem_enq, alu_enq, pop;

  logic [DEPTH-1:0][ADDR_W-1:0] ent_da;
  logic                         hit_a, hit_b;
  logic [DATA_W-1:0]            match_d_a, match_d_b;
`ifdef WBQ_FORWARD_EN
  logic [DEPTH-1:0][DATA_W-1:0] ent_dv;
`endif

  // Free space ignores the same-cycle pop so acceptance never depends on draining.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    mem_ready = rst_n && (free != '0);
    alu_ready = rst_n && (mem_valid ? (free >= CW'(2)) : (free != '0));
    mem_enq   = mem_valid && mem_ready && (mem_da != '0);
    alu_enq   = alu_valid && alu_ready && (alu_da != '0);
    pop       = (count_q != '0);
    alu_slot  = tail_q + PTR_W'(mem_enq);
    head_d    = head_q + PTR_W'(pop);
    tail_d    = tail_q + PTR_W'(mem_enq) + PTR_W'(alu_enq);
    count_d   = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (mem_enq) ent_q[tail_q]   <= '{da: mem_da, d: mem_d};
    if (alu_enq) ent_q[alu_slot] <= '{da: alu_da, d: alu_d};
  end

  always_comb begin
    rf_rw = pop;
    rf_da = pop ? ent_q[head_q].da : '0;
    rf_d  = pop ? ent_q[head_q].d  : '0;
    count = count_q;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_da[i] = ent_q[i].da;
`ifdef WBQ_FORWARD_EN
      ent_dv[i] = ent_q[i].d;
`endif
    end
  end

  wbq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_a (
    .addr_i  (aa),
    .da_i    (ent_da),
`ifdef WBQ_FORWARD_EN
    .d_i     (ent_dv),
`endif
    .head_i  (head_q),
    .count_i (count_q),
    .hit_o   (hit_a),
    .data_o  (match_d_a)
  );

  wbq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_b (
    .addr_i  (ba),
    .da_i    (ent_da),
`ifdef WBQ_FORWARD_EN
    .d_i     (ent_dv),
`endif
    .head_i  (head_q),
    .count_i (count_q),
    .hit_o   (hit_b),
    .data_o  (match_d_b)
  );

  always_comb begin
    hazard_a = hit_a;
    hazard_b = hit_b;
    fwd_a    = match_d_a;
    fwd_b    = match_d_b;
`ifdef WBQ_FORWARD_EN
    fwd_a_hit = hit_a;
    fwd_b_hit = hit_b;
`else
    fwd_a_hit = 1'b0;
    fwd_b_hit = 1'b0;
`endif
  end

endmodule
